// File: rtl/rc5_key_expand_if.sv
// ============================================================================
// Module      : rc5_key_expand_if
// Description : Start/key/read-port bundle between the RC5 key schedule and
//               the round engine that consumes the S table.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rc5_key_expand_if #(
    parameter int W        = 32,
    parameter int B        = 16,
    parameter int T_LENGTH = 5
);
    logic                iStart;
    logic [8*B-1:0]      iKey;
    logic [T_LENGTH-1:0] iS_address1;
    logic [T_LENGTH-1:0] iS_address2;
    logic [W-1:0]        oS_sub_i1;
    logic [W-1:0]        oS_sub_i2;
    logic                oBusy;
    logic                oDone;

    modport master (
        output iStart, iKey, iS_address1, iS_address2,
        input  oS_sub_i1, oS_sub_i2, oBusy, oDone
    );

    modport slave (
        input  iStart, iKey, iS_address1, iS_address2,
        output oS_sub_i1, oS_sub_i2, oBusy, oDone
    );
endinterface

`default_nettype wire

// File: rtl/rc5_key_expand.sv
// ============================================================================
// Module      : rc5_key_expand
// Description : RC5 key schedule; expands a B-byte key into the T-word S table
//               and serves it through two registered read ports.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rc5_key_expand #(
    parameter int W        = 32,
    parameter int R        = 12,
    parameter int B        = 16,
    parameter int T        = 2 * (R + 1),
    parameter int C        = ((8 * B + W - 1) / W < 1) ? 1 : (8 * B + W - 1) / W,
    parameter int T_LENGTH = $clog2(T),
    parameter int N        = 3 * ((T > C) ? T : C)
) (
    input  wire  clk,
    input  wire  rst_n,
    rc5_key_expand_if.slave bus
);
    localparam int LOGW   = $clog2(W);
    localparam int KW     = $clog2(N + 1);
    localparam int CW     = (C > 1) ? $clog2(C) : 1;
    localparam int LDEPTH = 2 ** CW;
    localparam int U      = W / 8;

    localparam logic [W-1:0] P_CONST = (W == 16) ? W'(16'hB7E1) : W'(32'hB7E15163);
    localparam logic [W-1:0] Q_CONST = (W == 16) ? W'(16'h9E37) : W'(32'h9E3779B9);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOAD_L = 3'd1;
    localparam logic [2:0] INIT_S = 3'd2;
    localparam logic [2:0] MIX_A  = 3'd3;
    localparam logic [2:0] MIX_B  = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;

    logic [W-1:0]        s_mem [T];
    logic [W-1:0]        l_mem [LDEPTH];
    logic [2:0]          state;
    logic [W-1:0]        reg_a;
    logic [W-1:0]        reg_b;
    logic [T_LENGTH-1:0] idx_i;
    logic [CW-1:0]       idx_j;
    logic [KW-1:0]       cnt_k;
    logic                busy;
    logic                done;
    logic [W-1:0]        sub1;
    logic [W-1:0]        sub2;

    function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [LOGW-1:0] n);
        logic [2*W-1:0] t;
        t = {x, x} << n;
        return t[2*W-1:W];
    endfunction

    // Little-endian packing of key bytes into word m; bytes past B read as zero.
    function automatic logic [W-1:0] pack_word(input logic [8*B-1:0] key, input int m);
        logic [W-1:0]   w;
        logic [8*B-1:0] sh;
        w = '0;
        for (int bi = 0; bi < U; bi++) begin
            if (m * U + bi < B) begin
                sh = key >> (8 * (m * U + bi));
                w[8*bi +: 8] = sh[7:0];
            end
        end
        return w;
    endfunction

    logic                start_ok;
    logic [T_LENGTH-1:0] init_addr;
    logic [T_LENGTH-1:0] prev_addr;
    logic [W-1:0]        init_val;
    logic [W-1:0]        mix_a_val;
    logic [W-1:0]        ab_sum;
    logic [W-1:0]        mix_b_val;

    always_comb begin
        start_ok  = bus.iStart && ((state == IDLE) || (state == DONE));
        init_addr = cnt_k[T_LENGTH-1:0];
        prev_addr = (init_addr == '0) ? '0 : init_addr - 1'b1;
        init_val  = (cnt_k == '0) ? P_CONST : s_mem[prev_addr] + Q_CONST;
        mix_a_val = rotl(s_mem[idx_i] + reg_a + reg_b, LOGW'(3));
        // In MIX_B reg_a already holds the A' written on the preceding MIX_A edge.
        ab_sum    = reg_a + reg_b;
        mix_b_val = rotl(l_mem[idx_j] + ab_sum, ab_sum[LOGW-1:0]);
    end

    // Table storage carries no reset; oDone alone qualifies its contents.
    always_ff @(posedge clk) begin
        if (start_ok) begin
            for (int m = 0; m < C; m++) begin
                l_mem[m] <= pack_word(bus.iKey, m);
            end
        end else if (state == MIX_B) begin
            l_mem[idx_j] <= mix_b_val;
        end
        if (state == INIT_S) begin
            s_mem[init_addr] <= init_val;
        end else if (state == MIX_A) begin
            s_mem[idx_i] <= mix_a_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            reg_a <= '0;
            reg_b <= '0;
            idx_i <= '0;
            idx_j <= '0;
            cnt_k <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sub1  <= '0;
            sub2  <= '0;
        end else begin
            sub1 <= ({1'b0, bus.iS_address1} < (T_LENGTH + 1)'(T)) ? s_mem[bus.iS_address1] : '0;
            sub2 <= ({1'b0, bus.iS_address2} < (T_LENGTH + 1)'(T)) ? s_mem[bus.iS_address2] : '0;
            case (state)
                IDLE, DONE: begin
                    if (start_ok) begin
                        state <= INIT_S;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        cnt_k <= '0;
                    end
                end
                INIT_S: begin
                    if (cnt_k == KW'(T - 1)) begin
                        state <= MIX_A;
                        reg_a <= '0;
                        reg_b <= '0;
                        idx_i <= '0;
                        idx_j <= '0;
                        cnt_k <= '0;
                    end else begin
                        cnt_k <= cnt_k + 1'b1;
                    end
                end
                MIX_A: begin
                    reg_a <= mix_a_val;
                    state <= MIX_B;
                end
                MIX_B: begin
                    reg_b <= mix_b_val;
                    idx_i <= (idx_i == T_LENGTH'(T - 1)) ? '0 : idx_i + 1'b1;
                    idx_j <= (idx_j == CW'(C - 1)) ? '0 : idx_j + 1'b1;
                    cnt_k <= cnt_k + 1'b1;
                    if (cnt_k == KW'(N - 1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state <= MIX_A;
                    end
                end
                LOAD_L:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.oS_sub_i1 = sub1;
    assign bus.oS_sub_i2 = sub2;
    assign bus.oBusy     = busy;
    assign bus.oDone     = done;
endmodule

`default_nettype wire

// File: tb/tb_rc5_key_expand.sv
// ============================================================================
// Module      : tb_rc5_key_expand
// Description : Randomized self-checking bench for rc5_key_expand (W=32/B=16
//               and W=16/B=1 builds) against a C-style key-schedule model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rc5_key_expand;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rc5_key_expand_if #(.W(32), .B(16), .T_LENGTH(5)) bus32 ();
    rc5_key_expand_if #(.W(16), .B(1),  .T_LENGTH(5)) bus16 ();

    rc5_key_expand #(.W(32), .R(12), .B(16)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
    rc5_key_expand #(.W(16), .R(12), .B(1))  dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

    int checks = 0;
    int errors = 0;
    longint unsigned exp_s [26];
    longint unsigned got_s [26];

    task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic longint unsigned rotl_m(longint unsigned x, longint unsigned n,
                                               int w, longint unsigned mask);
        int sh;
        x  = x & mask;
        sh = int'(n % longint'(w));
        return ((x << sh) | (x >> (w - sh))) & mask;
    endfunction

    // Straight transcription of the reference key schedule.
    task automatic model(input logic [127:0] key, input int w, input int nb);
        longint unsigned mask, p, q, a, b;
        longint unsigned l [16];
        int u, c, n, ii, jj;
        mask = (w == 32) ? 64'hFFFF_FFFF : 64'hFFFF;
        p    = (w == 32) ? 64'hB7E1_5163 : 64'hB7E1;
        q    = (w == 32) ? 64'h9E37_79B9 : 64'h9E37;
        u    = w / 8;
        c    = (nb + u - 1) / u;
        if (c < 1) c = 1;
        for (int x = 0; x < 16; x++) l[x] = 0;
        for (int x = nb - 1; x >= 0; x--) l[x/u] = ((l[x/u] << 8) + longint'(key[8*x +: 8])) & mask;
        exp_s[0] = p;
        for (int x = 1; x < 26; x++) exp_s[x] = (exp_s[x-1] + q) & mask;
        a = 0; b = 0; ii = 0; jj = 0;
        n = 3 * ((26 > c) ? 26 : c);
        for (int t = 0; t < n; t++) begin
            a = rotl_m(exp_s[ii] + a + b, 3, w, mask);
            exp_s[ii] = a;
            b = rotl_m(l[jj] + a + b, (a + b) & mask, w, mask);
            l[jj] = b;
            ii = (ii + 1) % 26;
            jj = (jj + 1) % c;
        end
    endtask

    task automatic start32(input logic [127:0] key);
        bus32.iKey   = key;
        bus32.iStart = 1'b1;
        tick();
        bus32.iStart = 1'b0;
    endtask

    task automatic wait_done32(output int cyc);
        cyc = 0;
        while (!bus32.oDone && cyc < 400) begin
            tick();
            cyc++;
        end
    endtask

    task automatic read_table32(input string tag);
        for (int t = 0; t < 26; t++) begin
            bus32.iS_address1 = 5'(t);
            bus32.iS_address2 = 5'(25 - t);
            tick();
            got_s[t] = longint'(bus32.oS_sub_i1);
            check($sformatf("%s_p1_s%0d", tag, t), longint'(bus32.oS_sub_i1), exp_s[t]);
            check($sformatf("%s_p2_s%0d", tag, 25 - t), longint'(bus32.oS_sub_i2), exp_s[25-t]);
        end
    endtask

    function automatic longint unsigned rotl32(longint unsigned x, longint unsigned n);
        return rotl_m(x, n, 32, 64'hFFFF_FFFF);
    endfunction

    initial begin
        logic [127:0]    key, orig;
        int              cyc, busy_low;
        longint unsigned ca, cb;

        bus32.iStart = 1'b0; bus32.iKey = '0; bus32.iS_address1 = '0; bus32.iS_address2 = '0;
        bus16.iStart = 1'b0; bus16.iKey = '0; bus16.iS_address1 = '0; bus16.iS_address2 = '0;
        tick(); tick();
        check("rst_busy", longint'(bus32.oBusy), 0);
        check("rst_done", longint'(bus32.oDone), 0);
        check("rst_sub1", longint'(bus32.oS_sub_i1), 0);
        check("rst_sub2", longint'(bus32.oS_sub_i2), 0);
        rst_n = 1'b1;
        tick();

        // INIT_S values observed on the first MIX edges (reads return pre-write contents)
        key = {$urandom, $urandom, $urandom, $urandom};
        start32(key);
        busy_low = 0;
        for (int t = 0; t < 26; t++) begin
            if (!bus32.oBusy) busy_low++;
            tick();
        end
        bus32.iS_address1 = 5'd0;
        bus32.iS_address2 = 5'd1;
        tick();
        check("init_s0", longint'(bus32.oS_sub_i1), 64'hB7E1_5163);
        check("init_s1", longint'(bus32.oS_sub_i2), 64'h5618_CB1C);
        bus32.iS_address2 = 5'd2;
        tick();
        check("init_s2", longint'(bus32.oS_sub_i2), 64'hF450_44D5);
        check("init_busy_low_cycles", longint'(busy_low), 0);
        wait_done32(cyc);
        model(key, 32, 16);
        read_table32("rand0");

        // Zero key: latency, full table and the Rivest cipher vector
        start32('0);
        wait_done32(cyc);
        check("zero_latency", longint'(cyc), 182);
        check("zero_busy_at_done", longint'(bus32.oBusy), 0);
        model('0, 32, 16);
        read_table32("zero");
        ca = got_s[0];
        cb = got_s[1];
        for (int r = 1; r <= 12; r++) begin
            ca = (rotl32(ca ^ cb, cb) + got_s[2*r]) & 64'hFFFF_FFFF;
            cb = (rotl32(cb ^ ca, ca) + got_s[2*r+1]) & 64'hFFFF_FFFF;
        end
        check("rivest_a", ca, 64'hEEDB_A521);
        check("rivest_b", cb, 64'h6D8F_4B15);
        for (int t = 0; t < 5; t++) tick();
        check("done_held", longint'(bus32.oDone), 1);

        // Read-port boundaries
        bus32.iS_address1 = 5'd25;
        bus32.iS_address2 = 5'd31;
        tick();
        check("rd_addr25", longint'(bus32.oS_sub_i1), exp_s[25]);
        check("rd_addr31", longint'(bus32.oS_sub_i2), 0);
        bus32.iS_address1 = 5'd26;
        tick();
        check("rd_addr26", longint'(bus32.oS_sub_i1), 0);

        // Key/start disturbance mid-run is ignored
        for (int b = 0; b < 16; b++) orig[8*b +: 8] = 8'(b);
        start32(orig);
        for (int t = 0; t < 50; t++) tick();
        bus32.iKey   = {$urandom, $urandom, $urandom, $urandom};
        bus32.iStart = 1'b1;
        tick();
        bus32.iStart = 1'b0;
        wait_done32(cyc);
        check("midstart_latency", longint'(cyc + 51), 182);
        model(orig, 32, 16);
        read_table32("seq");

        // Asynchronous reset mid-expansion, then a clean restart
        key = {$urandom, $urandom, $urandom, $urandom};
        bus32.iS_address1 = 5'd0;
        bus32.iS_address2 = 5'd1;
        start32(key);
        for (int t = 0; t < 99; t++) tick();
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", longint'(bus32.oBusy), 0);
        check("arst_done", longint'(bus32.oDone), 0);
        check("arst_sub1", longint'(bus32.oS_sub_i1), 0);
        check("arst_sub2", longint'(bus32.oS_sub_i2), 0);
        tick();
        rst_n = 1'b1;
        tick();
        start32(key);
        wait_done32(cyc);
        check("arst_restart_latency", longint'(cyc), 182);
        model(key, 32, 16);
        read_table32("arst");

        // Extra random keys
        for (int r = 0; r < 2; r++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            start32(key);
            wait_done32(cyc);
            check($sformatf("rand%0d_latency", r + 1), longint'(cyc), 182);
            model(key, 32, 16);
            read_table32($sformatf("rand%0d", r + 1));
        end

        // W=16, single-byte key
        key = '0;
        key[7:0] = 8'($urandom_range(0, 255));
        bus16.iKey   = key[7:0];
        bus16.iStart = 1'b1;
        tick();
        bus16.iStart = 1'b0;
        cyc = 0;
        while (!bus16.oDone && cyc < 400) begin
            tick();
            cyc++;
        end
        check("w16_latency", longint'(cyc), 182);
        model(key, 16, 1);
        for (int t = 0; t < 26; t++) begin
            bus16.iS_address1 = 5'(t);
            tick();
            check($sformatf("w16_s%0d", t), longint'(bus16.oS_sub_i1), exp_s[t]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
